// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit_pkg
// Brief    : Shared constants, types and helpers for the IF-stage fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pc_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
    localparam logic [1:0] PCSEL_JAL   = 2'b01;
    localparam logic [1:0] PCSEL_BR    = 2'b10;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned BIOS_SEL_BIT = 30;
    localparam int unsigned IMEM_SEL_BIT = 28;

    typedef enum logic [1:0] {
        SRC_PLUS4 = 2'd0,
        SRC_JAL   = 2'd1,
        SRC_BR    = 2'd2,
        SRC_HOLD  = 2'd3
    } pc_src_e;

    function automatic logic is_bios(input logic [XLEN-1:0] addr);
        return addr[BIOS_SEL_BIT];
    endfunction

    function automatic logic is_imem(input logic [XLEN-1:0] addr);
        return !addr[BIOS_SEL_BIT] && addr[IMEM_SEL_BIT];
    endfunction

    // The X-stage redirect is older than the ID jump, so it wins; 11 is reserved.
    function automatic pc_src_e decode_pcsel(input logic stall, input logic [1:0] pcsel);
        pc_src_e src;
        if (stall) begin
            src = SRC_HOLD;
        end else begin
            case (pcsel)
                PCSEL_BR:    src = SRC_BR;
                PCSEL_JAL:   src = SRC_JAL;
                PCSEL_PLUS4: src = SRC_PLUS4;
                default:     src = SRC_PLUS4;
            endcase
        end
        return src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit_if
// Brief    : Instruction-memory bus between the fetch unit and BIOS/IMEM.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic [XLEN-1:0] fetch_addr;
    logic            bios_en;
    logic            imem_en;
    logic [XLEN-1:0] bios_dout;
    logic [XLEN-1:0] imem_dout;

    modport master (
        output fetch_addr,
        output bios_en,
        output imem_en,
        input  bios_dout,
        input  imem_dout
    );

    modport slave (
        input  fetch_addr,
        input  bios_en,
        input  imem_en,
        output bios_dout,
        output imem_dout
    );

endinterface
`default_nettype wire

// File: rtl/fetch_hold_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hold_reg
// Brief    : Holds a synchronous-read memory return value across stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_hold_reg
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = NOP_INSTR
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            stall,
    input  wire logic [XLEN-1:0] din,
    output logic      [XLEN-1:0] dout
);

    logic            r_stall;
    logic [XLEN-1:0] r_hold;
    logic [XLEN-1:0] w_out;

    // The memory read data is only valid the cycle after the address, so the
    // first stalled cycle's value must be captured and replayed until release.
    assign w_out = r_stall ? r_hold : din;
    assign dout  = w_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= 1'b0;
            r_hold  <= RESET_VAL;
        end else begin
            r_stall <= stall;
            if (stall) begin
                r_hold <= w_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : IF-stage PC generator, instruction return, squash and counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall,
    input  wire logic [1:0]  pcsel,
    input  wire logic [31:0] jal_target,
    input  wire logic [31:0] br_target,
    fetch_pc_unit_if.master  mem,
    output logic      [31:0] pc_id,
    output logic      [31:0] instr_id,
    output logic             valid_id,
    output logic      [31:0] cnt_fetch,
    output logic      [31:0] cnt_kill
);

    import fetch_pc_unit_pkg::*;

    logic [31:0] r_pc;
    logic [31:0] r_cnt_fetch;
    logic [31:0] r_cnt_kill;

    pc_src_e     w_src;
    logic [31:0] w_next_pc;
    logic [31:0] w_fetch_addr;
    logic [31:0] w_raw;
    logic [31:0] w_held;
    logic        w_kill;
    logic        w_valid;

    assign w_src = decode_pcsel(stall, pcsel);

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        case (w_src)
            SRC_HOLD:  w_next_pc = r_pc;
            SRC_BR:    w_next_pc = br_target;
            SRC_JAL:   w_next_pc = jal_target;
            SRC_PLUS4: w_next_pc = r_pc + 32'd4;
            default:   w_next_pc = r_pc + 32'd4;
        endcase
    end

    assign w_fetch_addr   = rst ? RESET_PC : w_next_pc;
    assign mem.fetch_addr = w_fetch_addr;
    assign mem.bios_en    = is_bios(w_fetch_addr);
    assign mem.imem_en    = is_imem(w_fetch_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // Return data belongs to r_pc, so the source is chosen from the registered PC.
    assign w_raw = r_pc[BIOS_SEL_BIT] ? mem.bios_dout : mem.imem_dout;

    fetch_hold_reg #(
        .RESET_VAL (NOP_INSTR)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .din   (w_raw),
        .dout  (w_held)
    );

    // A taken branch/JALR in X makes the instruction now in decode wrong-path.
    assign w_kill  = (pcsel == PCSEL_BR) && !stall && !rst;
    assign w_valid = !rst && !w_kill;

    assign instr_id = w_valid ? w_held : NOP_INSTR;
    assign pc_id    = rst ? RESET_PC : r_pc;
    assign valid_id = w_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_fetch <= 32'd0;
            r_cnt_kill  <= 32'd0;
        end else begin
            if (w_valid && !stall) begin
                r_cnt_fetch <= r_cnt_fetch + 32'd1;
            end
            if (w_kill) begin
                r_cnt_kill <= r_cnt_kill + 32'd1;
            end
        end
    end

    assign cnt_fetch = r_cnt_fetch;
    assign cnt_kill  = r_cnt_kill;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Brief    : Self-checking bench for fetch_pc_unit with a 1-cycle memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic [1:0]  pcsel;
        logic [31:0] jal;
        logic [31:0] br;
        logic        garb;
        logic [31:0] e_fa;
        logic [31:0] e_pc;
        logic        e_nop;
        logic        e_valid;
        logic [31:0] e_cf;
        logic [31:0] e_ck;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pcsel = 2'b00;
    logic [31:0] jal_target = 32'd0;
    logic [31:0] br_target = 32'd0;
    logic        garb = 1'b0;

    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic [31:0] cnt_fetch;
    logic [31:0] cnt_kill;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];
    vec_t sb[$];

    fetch_pc_unit_if mem_if ();

    fetch_pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pcsel      (pcsel),
        .jal_target (jal_target),
        .br_target  (br_target),
        .mem        (mem_if),
        .pc_id      (pc_id),
        .instr_id   (instr_id),
        .valid_id   (valid_id),
        .cnt_fetch  (cnt_fetch),
        .cnt_kill   (cnt_kill)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bios_word(input logic [31:0] a);
        return a ^ 32'hB105_0000;
    endfunction

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'h1E3E_0000;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] t;
        t = a;
        return t[30] ? bios_word(t) : imem_word(t);
    endfunction

    // Synchronous-read memories; garbage mode scrambles the return lines.
    always @(posedge clk) begin
        if (garb) begin
            mem_if.bios_dout <= $urandom;
            mem_if.imem_dout <= $urandom;
        end else begin
            mem_if.bios_dout <= bios_word(mem_if.fetch_addr);
            mem_if.imem_dout <= imem_word(mem_if.fetch_addr);
        end
    end

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] ps,
                                input logic [31:0] j, input logic [31:0] b, input logic g,
                                input logic [31:0] fa, input logic [31:0] pc,
                                input logic nop, input logic vld,
                                input logic [31:0] cf, input logic [31:0] ck);
        vec_t v;
        v.rst = r;   v.stall = s; v.pcsel = ps; v.jal = j; v.br = b; v.garb = g;
        v.e_fa = fa; v.e_pc = pc; v.e_nop = nop; v.e_valid = vld;
        v.e_cf = cf; v.e_ck = ck;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_out();
        vec_t        e;
        logic [31:0] e_instr;
        logic [31:0] fa;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e       = sb.pop_front();
        fa      = e.e_fa;
        e_instr = e.e_nop ? 32'h0000_0013 : exp_word(e.e_pc);
        chk("fetch_addr", mem_if.fetch_addr, fa);
        chk("pc_id", pc_id, e.e_pc);
        chk("instr_id", instr_id, e_instr);
        chk("valid_id", {31'd0, valid_id}, {31'd0, e.e_valid});
        chk("bios_en", {31'd0, mem_if.bios_en}, {31'd0, fa[30]});
        chk("imem_en", {31'd0, mem_if.imem_en}, {31'd0, (!fa[30] && fa[28])});
        chk("cnt_fetch", cnt_fetch, e.e_cf);
        chk("cnt_kill", cnt_kill, e.e_ck);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst        = v.rst;
        stall      = v.stall;
        pcsel      = v.pcsel;
        jal_target = v.jal;
        br_target  = v.br;
        garb       = v.garb;
        sb.push_back(v);
        #1;
        compare_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset, sequential fetch, branch squash, JAL, reserved code
        tbl.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 32'h4000_0000,32'h4000_0000,1,0, 0,0));
        tbl.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 32'h4000_0000,32'h4000_0000,1,0, 0,0));
        tbl.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h4000_0004,32'h4000_0000,0,1, 0,0));
        tbl.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h4000_0008,32'h4000_0004,0,1, 1,0));
        tbl.push_back(mk(0,0,2'b10,32'h0,32'h1000_0040,0, 32'h1000_0040,32'h4000_0008,1,0, 2,0));
        tbl.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h1000_0044,32'h1000_0040,0,1, 2,1));
        tbl.push_back(mk(0,0,2'b01,32'h4000_0100,32'h0,0, 32'h4000_0100,32'h1000_0044,0,1, 3,1));
        tbl.push_back(mk(0,0,2'b11,32'h0,32'h0,0, 32'h4000_0104,32'h4000_0100,0,1, 4,1));
        tbl.push_back(mk(0,0,2'b10,32'h4000_0200,32'h4000_0010,0, 32'h4000_0010,32'h4000_0104,1,0, 5,1));
        // three stall cycles with garbage return data and ignored redirects
        tbl.push_back(mk(0,1,2'b10,32'h0,32'hDEAD_BEE0,1, 32'h4000_0010,32'h4000_0010,0,1, 5,2));
        tbl.push_back(mk(0,1,2'b10,32'h0,32'hDEAD_BEE0,1, 32'h4000_0010,32'h4000_0010,0,1, 5,2));
        tbl.push_back(mk(0,1,2'b01,32'h4000_0300,32'h0,1, 32'h4000_0010,32'h4000_0010,0,1, 5,2));
        tbl.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h4000_0014,32'h4000_0010,0,1, 5,2));
        tbl.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h4000_0018,32'h4000_0014,0,1, 6,2));
        // wrap at the top of the address space, misaligned JAL target
        tbl.push_back(mk(0,0,2'b10,32'h0,32'hFFFF_FFFC,0, 32'hFFFF_FFFC,32'h4000_0018,1,0, 7,2));
        tbl.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h0000_0000,32'hFFFF_FFFC,0,1, 7,3));
        tbl.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h0000_0004,32'h0000_0000,0,1, 8,3));
        tbl.push_back(mk(0,0,2'b01,32'h1000_0102,32'h0,0, 32'h1000_0102,32'h0000_0004,0,1, 9,3));
        // reset during a stall with a pending redirect
        tbl.push_back(mk(0,1,2'b00,32'h0,32'h0,0, 32'h1000_0102,32'h1000_0102,0,1, 10,3));
        tbl.push_back(mk(1,1,2'b10,32'h0,32'h2000_0000,0, 32'h4000_0000,32'h4000_0000,1,0, 10,3));
        tbl.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h4000_0004,32'h4000_0000,0,1, 0,0));
        tbl.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h4000_0008,32'h4000_0004,0,1, 1,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // branch arriving on the stall-release cycle must squash the held slot
        apply(mk(0,1,2'b00,32'h0,32'h0,0, 32'h4000_0008,32'h4000_0008,0,1, 2,0));
        apply(mk(0,0,2'b10,32'h0,32'h1000_0000,0, 32'h1000_0000,32'h4000_0008,1,0, 2,0));
        apply(mk(0,0,2'b00,32'h0,32'h0,0, 32'h1000_0004,32'h1000_0000,0,1, 2,1));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
